// File: rtl/frame_buf_writer.sv
// frame_buf_writer: drains the capture FIFO in fixed bursts into a ring of frame buffers.
// Optional feature macro FBW_FRAME_SYNC_EN: frame_start arms each frame and aborts short frames.
module frame_buf_writer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 24,
    parameter int USEDW_W     = 12,
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 172800,
    parameter int NUM_BUFS    = 2,
    parameter int BASE_ADDR   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic [USEDW_W-1:0] fifo_rdusedw,
    input  logic               fifo_rdempty,
    output logic               fifo_rdreq,
    input  logic               frame_start,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    output logic [1:0]         wr_buf,
    output logic [1:0]         rd_buf,
    output logic               frame_done,
    output logic [7:0]         short_frames
);

    localparam int IDX_W = $clog2(FRAME_WORDS + 1);
    localparam int BC_W  = $clog2(BURST_LEN + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(FRAME_WORDS - 1);
    localparam logic [USEDW_W-1:0] BURST_USEDW = USEDW_W'(BURST_LEN);
    localparam logic [BC_W-1:0]    BURST_INIT  = BC_W'(BURST_LEN);
    localparam logic [1:0]         LAST_BUF    = 2'(NUM_BUFS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WRITE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BC_W-1:0]    r_burst_cnt;
    logic [IDX_W-1:0]   r_word_idx;
    logic [1:0]         r_wr_buf;
    logic [1:0]         r_rd_buf;
    logic               r_frame_done;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic               w_fifo_ready;
    logic               w_ack;
    logic               w_last_word;
    logic               w_complete;
    logic               w_burst_end;
    logic               w_abort;
    logic               w_may_start;
    logic               w_rdreq;
    logic               w_req;
    logic [1:0]         w_next_buf;

    // Start address of every possible buffer slot; entries past NUM_BUFS are never selected.
    logic [ADDR_W-1:0]  w_buf_base [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf_base
            assign w_buf_base[gi] = ADDR_W'(64'(BASE_ADDR) + 64'(gi) * 64'(FRAME_WORDS));
        end
    endgenerate

    assign w_fifo_ready = (fifo_rdusedw >= BURST_USEDW) && !fifo_rdempty;
    assign w_ack        = (r_state == WRITE) && mem_ack;
    assign w_last_word  = (r_word_idx == LAST_IDX);
    assign w_complete   = w_ack && w_last_word;
    assign w_burst_end  = w_ack && (r_burst_cnt == BC_W'(1));
    assign w_next_buf   = (r_wr_buf == LAST_BUF) ? 2'd0 : r_wr_buf + 2'd1;

`ifdef FBW_FRAME_SYNC_EN
    logic       r_armed;
    logic       r_start_pend;
    logic [7:0] r_short_frames;
    logic       w_start_mid;
    logic       w_pend;

    // A start that lands mid-frame is held until the running burst has drained.
    assign w_start_mid = frame_start && (r_word_idx != '0);
    assign w_pend      = r_start_pend || w_start_mid;
    assign w_abort     = w_pend && !w_complete && (w_burst_end || (r_state == IDLE));
    assign w_may_start = r_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed        <= 1'b0;
            r_start_pend   <= 1'b0;
            r_short_frames <= 8'd0;
        end else begin
            if (w_complete) begin
                r_armed <= w_pend;
            end else if (frame_start) begin
                r_armed <= 1'b1;
            end
            if (w_complete || w_abort) begin
                r_start_pend <= 1'b0;
            end else if (w_start_mid) begin
                r_start_pend <= 1'b1;
            end
            if (w_abort && (r_short_frames != 8'hFF)) begin
                r_short_frames <= r_short_frames + 8'd1;
            end
        end
    end

    assign short_frames = r_short_frames;
`else
    logic w_unused_frame_start;

    assign w_unused_frame_start = frame_start;
    assign w_abort              = 1'b0;
    assign w_may_start          = 1'b1;
    assign short_frames         = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rdreq      = 1'b0;
        w_req        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fifo_ready && w_may_start) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_rdreq      = 1'b1;
                w_state_next = CAPTURE;
            end
            CAPTURE: begin
                w_state_next = WRITE;
            end
            WRITE: begin
                w_req = 1'b1;
                if (mem_ack) begin
                    w_state_next = (r_burst_cnt == BC_W'(1)) ? IDLE : FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst_cnt  <= '0;
            r_word_idx   <= '0;
            r_wr_buf     <= 2'd0;
            r_rd_buf     <= LAST_BUF;
            r_frame_done <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_frame_done <= w_complete;
            if (r_state == IDLE) begin
                r_burst_cnt <= BURST_INIT;
            end
            // Address and data are latched together so both hold steady across wait states.
            if (r_state == CAPTURE) begin
                r_mem_wdata <= fifo_q;
                r_mem_addr  <= w_buf_base[r_wr_buf] + ADDR_W'(r_word_idx);
            end
            if (w_ack) begin
                r_burst_cnt <= r_burst_cnt - BC_W'(1);
                if (w_last_word) begin
                    r_word_idx <= '0;
                    r_rd_buf   <= r_wr_buf;
                    r_wr_buf   <= w_next_buf;
                end else begin
                    r_word_idx <= r_word_idx + IDX_W'(1);
                end
            end
            if (w_abort) begin
                r_word_idx <= '0;
            end
        end
    end

    assign fifo_rdreq = w_rdreq;
    assign mem_req    = w_req;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign wr_buf     = r_wr_buf;
    assign rd_buf     = r_rd_buf;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_buf_writer.sv
// Randomized bench for frame_buf_writer: FIFO and memory models plus a frame-level reference model.
module tb_frame_buf_writer;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 24;
    localparam int USEDW_W = 12;
    localparam int BL      = 8;
    localparam int FW      = 16;
    localparam int NB      = 2;
    localparam int BASE    = 0;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [DATA_W-1:0]  fifo_q = '0;
    logic [USEDW_W-1:0] fifo_rdusedw = '0;
    logic               fifo_rdempty = 1'b1;
    logic               fifo_rdreq;
    logic               frame_start = 1'b0;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ack = 1'b0;
    logic [1:0]         wr_buf;
    logic [1:0]         rd_buf;
    logic               frame_done;
    logic [7:0]         short_frames;

    frame_buf_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .USEDW_W(USEDW_W), .BURST_LEN(BL),
        .FRAME_WORDS(FW), .NUM_BUFS(NB), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .fifo_q(fifo_q), .fifo_rdusedw(fifo_rdusedw),
        .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq), .frame_start(frame_start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .wr_buf(wr_buf), .rd_buf(rd_buf), .frame_done(frame_done), .short_frames(short_frames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // FIFO model
    logic [DATA_W-1:0] fifo_mem[$];
    logic [DATA_W-1:0] push_q[$];
    bit                pop_pend = 1'b0;
    int                underflow = 0;

    // memory / monitor state
    bit                in_req = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    int                wait_cnt = 0, cur_wait = 0, ack_wait = 0;
    bit                rand_wait = 1'b0, spurious = 1'b0;
    int                rdreq_cnt = 0, req_cycles = 0, unstable = 0, done_cnt = 0;
    int                rdreq_cyc[$], ack_cyc[$], done_rd[$], done_wr[$];
    logic [ADDR_W-1:0] mon_addr[$];
    logic [DATA_W-1:0] mon_data[$];

    // reference model
    logic [DATA_W-1:0] exp_data[$];
    int                m_idx = 0, m_buf = 0, m_rd = NB - 1, m_done = 0, m_short = 0;
    int                exp_rd[$], exp_wr[$];

    always @(posedge clk) begin
        cyc++;
        if (pop_pend) begin
            if (fifo_mem.size() > 0) fifo_q <= fifo_mem.pop_front();
            else underflow++;
        end
        while (push_q.size() > 0) fifo_mem.push_back(push_q.pop_front());
        fifo_rdusedw <= USEDW_W'(fifo_mem.size());
        fifo_rdempty <= (fifo_mem.size() == 0);
    end

    always @(negedge clk) begin
        pop_pend = fifo_rdreq;
        mem_ack  = 1'b0;
        if (reset) begin
            in_req = 1'b0;
        end else begin
            if (fifo_rdreq) begin
                rdreq_cnt++;
                rdreq_cyc.push_back(cyc);
            end
            if (frame_done) begin
                done_cnt++;
                done_rd.push_back(int'(rd_buf));
                done_wr.push_back(int'(wr_buf));
            end
            if (mem_req) begin
                req_cycles++;
                if (!in_req) begin
                    in_req    = 1'b1;
                    hold_addr = mem_addr;
                    hold_data = mem_wdata;
                    wait_cnt  = 0;
                    cur_wait  = rand_wait ? int'($urandom_range(0, 3)) : ack_wait;
                end else if (mem_addr !== hold_addr || mem_wdata !== hold_data) begin
                    unstable++;
                end
                if (wait_cnt >= cur_wait) begin
                    mem_ack = 1'b1;
                    in_req  = 1'b0;
                    mon_addr.push_back(hold_addr);
                    mon_data.push_back(hold_data);
                    ack_cyc.push_back(cyc);
                end else begin
                    wait_cnt++;
                end
            end else begin
                in_req = 1'b0;
                if (spurious) mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_words(input int n, input bit seq, input logic [DATA_W-1:0] first);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = seq ? first + DATA_W'(i) : DATA_W'($urandom);
            push_q.push_back(w);
            exp_data.push_back(w);
        end
    endtask

    task automatic arm_if_needed();
`ifdef FBW_FRAME_SYNC_EN
        if (m_idx == 0) begin
            @(negedge clk) frame_start = 1'b1;
            @(negedge clk) frame_start = 1'b0;
        end
`endif
    endtask

    task automatic wait_writes(input int n, input string tag);
        int budget = 3000;
        while (mon_addr.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val(tag, 32'(mon_addr.size()), 32'(n));
    endtask

    task automatic model_step(output logic [ADDR_W-1:0] ea, output logic [DATA_W-1:0] ed);
        ed = (exp_data.size() > 0) ? exp_data.pop_front() : '0;
        ea = ADDR_W'(BASE + m_buf * FW + m_idx);
        m_idx++;
        if (m_idx == FW) begin
            m_rd   = m_buf;
            m_buf  = (m_buf + 1) % NB;
            m_idx  = 0;
            m_done++;
            exp_rd.push_back(m_rd);
            exp_wr.push_back(m_buf);
        end
    endtask

    task automatic compare_writes(input int n);
        logic [ADDR_W-1:0] a, ea;
        logic [DATA_W-1:0] d, ed;
        for (int i = 0; i < n && mon_addr.size() > 0; i++) begin
            a = mon_addr.pop_front();
            d = mon_data.pop_front();
            model_step(ea, ed);
            $display("write addr=0x%0h data=0x%0h (expected addr=0x%0h data=0x%0h)", a, d, ea, ed);
            check_val("wr_addr", 32'(a), 32'(ea));
            check_val("wr_data", 32'(d), 32'(ed));
        end
    endtask

    task automatic check_status(input string tag);
        repeat (4) @(negedge clk);
        check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'(m_done));
        check_val({tag, "_rd_buf"}, 32'(rd_buf), 32'(m_rd));
        check_val({tag, "_wr_buf"}, 32'(wr_buf), 32'(m_buf));
        check_val({tag, "_short"}, 32'(short_frames), 32'(m_short));
    endtask

    initial begin
        int r0, q0;
        int budget;

        // reset values
        repeat (3) @(negedge clk);
        check_val("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_val("rst_wr_buf", 32'(wr_buf), 32'd0);
        check_val("rst_rd_buf", 32'(rd_buf), 32'(NB - 1));
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_short", 32'(short_frames), 32'd0);
        reset = 1'b0;

        // single burst, zero-wait
        arm_if_needed();
        rdreq_cyc.delete();
        ack_cyc.delete();
        @(negedge clk);
        push_words(BL, 1'b1, 16'h1000);
        wait_writes(BL, "burst_cnt");
        compare_writes(BL);
        check_val("burst_rdreqs", 32'(rdreq_cyc.size()), 32'(BL));
        for (int i = 1; i < BL && i < rdreq_cyc.size(); i++)
            check_val("rdreq_spacing", 32'(rdreq_cyc[i] - rdreq_cyc[i-1]), 32'd3);
        if (ack_cyc.size() == BL && rdreq_cyc.size() > 0)
            check_val("burst_len_cycles", 32'(ack_cyc[BL-1] - rdreq_cyc[0] + 1), 32'(3 * BL));
        else
            check_val("burst_acks", 32'(ack_cyc.size()), 32'(BL));

        // under threshold: BL-1 words must never start a burst
        r0 = rdreq_cnt;
        q0 = req_cycles;
        push_words(BL - 1, 1'b0, '0);
        repeat (1000) @(negedge clk);
        check_val("under_rdreq", 32'(rdreq_cnt - r0), 32'd0);
        check_val("under_mem_req", 32'(req_cycles - q0), 32'd0);
        push_words(1, 1'b0, '0);
        wait_writes(BL, "thresh_cnt");
        compare_writes(BL);
        check_status("frame0");

        // wait states
        ack_wait = 5;
        arm_if_needed();
        r0 = rdreq_cnt;
        q0 = unstable;
        push_words(BL, 1'b0, '0);
        wait_writes(BL, "wait_cnt");
        compare_writes(BL);
        check_val("wait_rdreq", 32'(rdreq_cnt - r0), 32'(BL));
        check_val("wait_stable", 32'(unstable - q0), 32'd0);

        // ping-pong streaming with random ack latency and stray acks
        ack_wait  = 0;
        rand_wait = 1'b1;
        spurious  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            arm_if_needed();
            push_words(int'($urandom_range(1, BL - 1)), 1'b0, '0);
            repeat (int'($urandom_range(0, 20))) @(negedge clk);
            push_words(BL - (exp_data.size() % BL == 0 ? BL : exp_data.size() % BL), 1'b0, '0);
            wait_writes(BL, "pp_cnt");
            compare_writes(BL);
        end
        check_status("pingpong");
        check_val("pp_frames", 32'(done_cnt), 32'd3);
        check_val("pp_seq_len", 32'(done_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < done_rd.size(); i++) begin
            check_val("pp_rd_seq", 32'(done_rd[i]), 32'(exp_rd[i]));
            check_val("pp_wr_seq", 32'(done_wr[i]), 32'(exp_wr[i]));
        end

        // frame_start in the middle of a frame
        arm_if_needed();
        push_words(BL, 1'b0, '0);
        wait_writes(3, "fs_pre");
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        wait_writes(BL, "fs_cnt");
        compare_writes(BL);
`ifdef FBW_FRAME_SYNC_EN
        m_idx = 0;
        m_short++;
`endif
        check_status("short");
        arm_if_needed();
        push_words(BL, 1'b0, '0);
        wait_writes(BL, "fs_post");
        compare_writes(BL);
        check_status("after_short");

        // reset in the middle of a write
        rand_wait = 1'b0;
        spurious  = 1'b0;
        ack_wait  = 10;
        arm_if_needed();
        push_words(BL, 1'b0, '0);
        budget = 500;
        while (!mem_req && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val("mid_req_seen", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_mem_req", 32'(mem_req), 32'd0);
        check_val("mid_rd_buf", 32'(rd_buf), 32'(NB - 1));
        check_val("mid_wr_buf", 32'(wr_buf), 32'd0);
        check_val("mid_rdreq", 32'(fifo_rdreq), 32'd0);
        check_val("mid_mem_addr", 32'(mem_addr), 32'd0);
        fifo_mem.delete();
        push_q.delete();
        exp_data.delete();
        mon_addr.delete();
        mon_data.delete();
        m_idx = 0; m_buf = 0; m_rd = NB - 1; m_short = 0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        ack_wait = 0;
        arm_if_needed();
        push_words(BL, 1'b0, '0);
        wait_writes(BL, "restart_cnt");
        compare_writes(BL);
        check_val("restart_wr_buf", 32'(wr_buf), 32'd0);
        check_val("fifo_underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
